// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: MEM-stage store/load side, drain control and
// the write port toward the data cache controller.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              st_valid;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic              st_ready;

   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;

   logic              drain_req;
   logic              drain_busy;

   logic              cache_wr_valid;
   logic [ADDR_W-1:0] cache_wr_addr;
   logic [DATA_W-1:0] cache_wr_data;
   logic              cache_wr_ready;

   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;

   modport master (
      output st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, cache_wr_ready,
      input  st_ready, ld_hit, ld_data, drain_busy, cache_wr_valid, cache_wr_addr,
             cache_wr_data, count, empty, full
   );

   modport slave (
      input  st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, cache_wr_ready,
      output st_ready, ld_hit, ld_data, drain_busy, cache_wr_valid, cache_wr_addr,
             cache_wr_data, count, empty, full
   );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer with youngest-first load forwarding and a drain mode
// that pushes every buffered store to the cache ahead of a cache flush.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clock,
   input  logic          reset,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = ADDR_W - 2;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t            state_reg;
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              hold_reg;
   logic              valid_reg [DEPTH];
   logic [TAG_W-1:0]  tag_reg   [DEPTH];
   logic [DATA_W-1:0] data_reg  [DEPTH];

   logic [TAG_W-1:0]  st_tag;
   logic [TAG_W-1:0]  ld_tag;
   logic              empty;
   logic              full;
   logic              st_ready;
   logic              push;
   logic              pop;
   logic              wr_valid;
   logic [DEPTH-1:0]  match;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic [PTR_W-1:0]  fwd_idx;
   logic              unused_addr_bits;

   assign st_tag           = bus.st_addr[ADDR_W-1:2];
   assign ld_tag           = bus.ld_addr[ADDR_W-1:2];
   assign unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(DEPTH));
   assign st_ready = !full && (state_reg != FLUSH);
   assign push     = bus.st_valid && st_ready;
   // Loads own the cache port in IDLE, but an offer already on the bus is never withdrawn.
   assign wr_valid   = !empty && (hold_reg || (state_reg == FLUSH) || !bus.ld_valid);
   assign pop        = wr_valid && bus.cache_wr_ready;
   assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign match[gi] = valid_reg[gi] && (tag_reg[gi] == ld_tag);

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               valid_reg[gi] <= 1'b0;
               tag_reg[gi]   <= '0;
               data_reg[gi]  <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
               valid_reg[gi] <= 1'b1;
               tag_reg[gi]   <= st_tag;
               data_reg[gi]  <= bus.st_data;
            end else if (pop && (head_reg == PTR_W'(gi))) begin
               valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_reg;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_reg + PTR_W'(i);
         if (match[fwd_idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_reg[fwd_idx];
         end
      end
      if (push && (st_tag == ld_tag)) begin
         fwd_hit  = 1'b1;
         fwd_data = bus.st_data;
      end
      if (!bus.ld_valid) begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         hold_reg  <= 1'b0;
         state_reg <= IDLE;
      end else begin
         if (push) tail_reg <= tail_reg + PTR_W'(1);
         if (pop)  head_reg <= head_reg + PTR_W'(1);
         count_reg <= count_next;
         hold_reg  <= wr_valid && !bus.cache_wr_ready;
         // No pushes are accepted in FLUSH, so an empty-entry drain leaves after one cycle.
         case (state_reg)
            IDLE:  if (bus.drain_req) state_reg <= FLUSH;
            FLUSH: if (count_next == '0) state_reg <= IDLE;
         endcase
      end
   end

   assign bus.st_ready       = st_ready;
   assign bus.ld_hit         = fwd_hit;
   assign bus.ld_data        = fwd_data;
   assign bus.drain_busy     = (state_reg == FLUSH);
   assign bus.cache_wr_valid = wr_valid;
   assign bus.cache_wr_addr  = {tag_reg[head_reg], 2'b00};
   assign bus.cache_wr_data  = data_reg[head_reg];
   assign bus.count          = count_reg;
   assign bus.empty          = empty;
   assign bus.full           = full;
endmodule
